// File: rtl/mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_arbiter_if
// Bundles the fetch port, the data port, the pipeline stall line and the
// asynchronous-SRAM pins of mem_arbiter. Signal suffixes are written from the
// arbiter's point of view (_i = into the arbiter, _o = out of it).
//   slave  : the arbiter itself
//   master : the environment (fetch unit, data stage, SRAM device)
// ---------------------------------------------------------------------------
interface mem_arbiter_if;
   // instruction-fetch port
   logic        if_req_i;
   logic [15:0] if_addr_i;
   logic [15:0] if_rdata_o;
   logic        if_ack_o;
   // data-stage port
   logic        mem_rd_i;
   logic        mem_wr_i;
   logic [15:0] mem_addr_i;
   logic [15:0] mem_wdata_i;
   logic [15:0] mem_rdata_o;
   logic        mem_ack_o;
   // pipeline freeze
   logic        stall_o;
   // SRAM pins
   logic [15:0] sram_addr_o;
   logic [15:0] sram_dout_o;
   logic        sram_dq_oe_o;
   logic [15:0] sram_din_i;
   logic        sram_ce_n_o;
   logic        sram_oe_n_o;
   logic        sram_we_n_o;

   modport slave (
      input  if_req_i, if_addr_i,
      input  mem_rd_i, mem_wr_i, mem_addr_i, mem_wdata_i,
      input  sram_din_i,
      output if_rdata_o, if_ack_o,
      output mem_rdata_o, mem_ack_o,
      output stall_o,
      output sram_addr_o, sram_dout_o, sram_dq_oe_o,
      output sram_ce_n_o, sram_oe_n_o, sram_we_n_o
   );

   modport master (
      output if_req_i, if_addr_i,
      output mem_rd_i, mem_wr_i, mem_addr_i, mem_wdata_i,
      output sram_din_i,
      input  if_rdata_o, if_ack_o,
      input  mem_rdata_o, mem_ack_o,
      input  stall_o,
      input  sram_addr_o, sram_dout_o, sram_dq_oe_o,
      input  sram_ce_n_o, sram_oe_n_o, sram_we_n_o
   );
endinterface

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Shares one asynchronous 16-bit SRAM between the instruction-fetch port and
// the data-stage port. A single FSM sequences each access; every SRAM pin and
// every ack/rdata output is a register loaded on the state transition, so the
// outputs are glitch-free and depend only on state.
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : mem_arbiter_if.slave (fetch port, data port, stall, SRAM pins)
// Read : IDLE -> RD1 -> RD2 -> DONE -> IDLE   (ack in 3rd cycle after grant)
// Write: IDLE -> WR1 -> WR2 -> WR3 -> DONE -> IDLE (ack in 4th cycle)
// ---------------------------------------------------------------------------
module mem_arbiter (
   input  logic          clk,
   input  logic          rst,
   mem_arbiter_if.slave  bus
);

   typedef enum logic [2:0] {
      IDLE, RD1, RD2, WR1, WR2, WR3, DONE
   } state_t;

   state_t      state_q;
   logic        owner_data_q;   // 1: data port owns the access in flight
   logic        last_data_q;    // 1: most recent grant went to the data port
   logic [15:0] if_rdata_q;
   logic [15:0] mem_rdata_q;
   logic        if_ack_q;
   logic        mem_ack_q;
   logic [15:0] sram_addr_q;
   logic [15:0] sram_dout_q;
   logic        dq_oe_q;
   logic        ce_n_q;
   logic        oe_n_q;
   logic        we_n_q;

   logic        data_req;
   logic        fetch_wins;

   assign data_req = bus.mem_rd_i | bus.mem_wr_i;

   // Data port normally has priority; a pending fetch wins once right after a
   // data grant so a busy data stage cannot starve instruction fetch.
   assign fetch_wins = bus.if_req_i & (last_data_q | ~data_req);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         owner_data_q <= 1'b0;
         last_data_q  <= 1'b0;
         if_rdata_q   <= '0;
         mem_rdata_q  <= '0;
         if_ack_q     <= 1'b0;
         mem_ack_q    <= 1'b0;
         sram_addr_q  <= '0;
         sram_dout_q  <= '0;
         dq_oe_q      <= 1'b0;
         ce_n_q       <= 1'b1;
         oe_n_q       <= 1'b1;
         we_n_q       <= 1'b1;
      end else begin
         // NOTE: non-blocking assignments throughout, so every register here
         // sees the pre-edge value of every other register.
         if_ack_q  <= 1'b0;
         mem_ack_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (fetch_wins) begin
                  state_q      <= RD1;
                  owner_data_q <= 1'b0;
                  last_data_q  <= 1'b0;
                  sram_addr_q  <= bus.if_addr_i;
                  ce_n_q       <= 1'b0;
                  oe_n_q       <= 1'b0;
               end else if (bus.mem_wr_i) begin
                  // mem_rd together with mem_wr lands here: write wins
                  state_q      <= WR1;
                  owner_data_q <= 1'b1;
                  last_data_q  <= 1'b1;
                  sram_addr_q  <= bus.mem_addr_i;
                  sram_dout_q  <= bus.mem_wdata_i;
                  ce_n_q       <= 1'b0;
                  dq_oe_q      <= 1'b1;
               end else if (bus.mem_rd_i) begin
                  state_q      <= RD1;
                  owner_data_q <= 1'b1;
                  last_data_q  <= 1'b1;
                  sram_addr_q  <= bus.mem_addr_i;
                  ce_n_q       <= 1'b0;
                  oe_n_q       <= 1'b0;
               end
            end
            RD1: state_q <= RD2;
            RD2: begin
               // SRAM data has had two cycles to settle; capture on the way out
               state_q <= DONE;
               ce_n_q  <= 1'b1;
               oe_n_q  <= 1'b1;
               if (owner_data_q) begin
                  mem_rdata_q <= bus.sram_din_i;
                  mem_ack_q   <= 1'b1;
               end else begin
                  if_rdata_q  <= bus.sram_din_i;
                  if_ack_q    <= 1'b1;
               end
            end
            WR1: begin
               state_q <= WR2;
               we_n_q  <= 1'b0;
            end
            WR2: begin
               // we_n rises before address/data change: hold time for the SRAM
               state_q <= WR3;
               we_n_q  <= 1'b1;
            end
            WR3: begin
               state_q   <= DONE;
               ce_n_q    <= 1'b1;
               dq_oe_q   <= 1'b0;
               mem_ack_q <= 1'b1;
            end
            DONE: state_q <= IDLE;   // no grant here: the acked request may still be high
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.if_rdata_o   = if_rdata_q;
   assign bus.if_ack_o     = if_ack_q;
   assign bus.mem_rdata_o  = mem_rdata_q;
   assign bus.mem_ack_o    = mem_ack_q;
   assign bus.sram_addr_o  = sram_addr_q;
   assign bus.sram_dout_o  = sram_dout_q;
   assign bus.sram_dq_oe_o = dq_oe_q;
   assign bus.sram_ce_n_o  = ce_n_q;
   assign bus.sram_oe_n_o  = oe_n_q;
   assign bus.sram_we_n_o  = we_n_q;

   assign bus.stall_o = (bus.if_req_i & ~if_ack_q) | (data_req & ~mem_ack_q);

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
// Directed stimulus against mem_arbiter with a behavioural SRAM. Every issued
// access pushes its expected ack (port, cycle, both rdata registers) into a
// queue; an independent monitor pops and compares on each ack. Pin-level
// strobe/stall expectations are checked inline by the stimulus.
// cyc counts rising edges; a request driven at the negedge where cyc==c into
// an idle arbiter is granted at edge c+1, reads ack at cyc c+3, writes at c+4.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mem_arbiter_if bus ();

   mem_arbiter dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // ---------------- behavioural SRAM ----------------
   logic [15:0] sram_mem [0:65535];

   assign bus.sram_din_i = (!bus.sram_ce_n_o && !bus.sram_oe_n_o) ?
                           sram_mem[bus.sram_addr_o] : 16'hDEAD;

   always @(posedge clk) begin
      if (!bus.sram_ce_n_o && !bus.sram_we_n_o && bus.sram_dq_oe_o)
         sram_mem[bus.sram_addr_o] = bus.sram_dout_o;
   end

   // ---------------- bookkeeping ----------------
   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      bit          data_port;
      logic [15:0] if_rd;
      logic [15:0] mem_rd;
      int          ack_cyc;
   } exp_t;

   exp_t        exp_q [$];
   exp_t        mon_e;
   logic [15:0] mdl_if_rd  = 16'h0;
   logic [15:0] mdl_mem_rd = 16'h0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", name, act, exp, cyc);
      end
   endtask

   // Queue the expected ack; rdata model updates only for reads of that port.
   task automatic expect_ack(input bit dp, input bit is_wr, input logic [15:0] rd,
                             input int ack_cyc);
      exp_t e;
      if (!is_wr) begin
         if (dp) mdl_mem_rd = rd;
         else    mdl_if_rd  = rd;
      end
      e.data_port = dp;
      e.if_rd     = mdl_if_rd;
      e.mem_rd    = mdl_mem_rd;
      e.ack_cyc   = ack_cyc;
      exp_q.push_back(e);
   endtask

   // Wait (bounded) for the port's ack, drop the request, step to an idle cycle.
   task automatic wait_ack_drop(input bit dp);
      bit seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (dp ? bus.mem_ack_o : bus.if_ack_o) seen = 1'b1;
      end
      check("ack_timeout", seen, 1);
      if (dp) begin
         bus.mem_rd_i = 1'b0;
         bus.mem_wr_i = 1'b0;
      end else begin
         bus.if_req_i = 1'b0;
      end
      @(negedge clk);
   endtask

   task automatic check_idle_pins(input string tag);
      check({tag, "_ce_n"},  bus.sram_ce_n_o,  1);
      check({tag, "_oe_n"},  bus.sram_oe_n_o,  1);
      check({tag, "_we_n"},  bus.sram_we_n_o,  1);
      check({tag, "_dq_oe"}, bus.sram_dq_oe_o, 0);
   endtask

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      if (!rst && (bus.if_ack_o || bus.mem_ack_o)) begin
         check("single_ack", bus.if_ack_o & bus.mem_ack_o, 0);
         if (exp_q.size() == 0) begin
            check("unexpected_ack", {bus.if_ack_o, bus.mem_ack_o}, 0);
         end else begin
            mon_e = exp_q.pop_front();
            check("ack_port",  bus.mem_ack_o,   mon_e.data_port);
            check("ack_cycle", cyc,             mon_e.ack_cyc);
            check("if_rdata",  bus.if_rdata_o,  mon_e.if_rd);
            check("mem_rdata", bus.mem_rdata_o, mon_e.mem_rd);
         end
      end
   end

   initial begin
      #20000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   // ---------------- stimulus ----------------
   initial begin
      int c;
      int nif;
      int nmem;

      bus.if_req_i    = 1'b0;
      bus.if_addr_i   = 16'h0;
      bus.mem_rd_i    = 1'b0;
      bus.mem_wr_i    = 1'b0;
      bus.mem_addr_i  = 16'h0;
      bus.mem_wdata_i = 16'h0;
      sram_mem[16'h0040] = 16'h6301;
      sram_mem[16'h0100] = 16'h1111;
      sram_mem[16'h0200] = 16'h2222;
      sram_mem[16'h0010] = 16'h7777;
      rst = 1'b1;

      // reset state
      repeat (3) @(negedge clk);
      check_idle_pins("rst");
      check("rst_if_ack",    bus.if_ack_o,    0);
      check("rst_mem_ack",   bus.mem_ack_o,   0);
      check("rst_if_rdata",  bus.if_rdata_o,  0);
      check("rst_mem_rdata", bus.mem_rdata_o, 0);
      check("rst_sram_addr", bus.sram_addr_o, 0);
      check("rst_sram_dout", bus.sram_dout_o, 0);
      check("rst_stall",     bus.stall_o,     0);
      rst = 1'b0;
      @(negedge clk);
      check_idle_pins("idle");

      // write 0x00A5 -> 0xBF00, inputs scrambled after grant
      c = cyc;
      bus.mem_wr_i = 1'b1; bus.mem_addr_i = 16'hBF00; bus.mem_wdata_i = 16'h00A5;
      #1 check("wr_stall_req", bus.stall_o, 1);
      expect_ack(1'b1, 1'b1, 16'h0, c + 4);
      @(negedge clk);   // WR1
      check("wr1_ce_n",  bus.sram_ce_n_o,  0);
      check("wr1_we_n",  bus.sram_we_n_o,  1);
      check("wr1_dq_oe", bus.sram_dq_oe_o, 1);
      check("wr1_addr",  bus.sram_addr_o,  16'hBF00);
      check("wr1_dout",  bus.sram_dout_o,  16'h00A5);
      bus.mem_addr_i = 16'h1234; bus.mem_wdata_i = 16'hFFFF;
      @(negedge clk);   // WR2
      check("wr2_we_n",  bus.sram_we_n_o,  0);
      check("wr2_addr",  bus.sram_addr_o,  16'hBF00);
      check("wr2_dout",  bus.sram_dout_o,  16'h00A5);
      @(negedge clk);   // WR3
      check("wr3_we_n",  bus.sram_we_n_o,  1);
      check("wr3_ce_n",  bus.sram_ce_n_o,  0);
      check("wr3_addr",  bus.sram_addr_o,  16'hBF00);
      check("wr3_dout",  bus.sram_dout_o,  16'h00A5);
      wait_ack_drop(1'b1);
      check("wr_sram_bf00", sram_mem[16'hBF00], 16'h00A5);
      check("wr_sram_1234", sram_mem[16'h1234] === 16'hFFFF, 0);

      // fetch 0x0040 -> 0x6301
      c = cyc;
      bus.if_req_i = 1'b1; bus.if_addr_i = 16'h0040;
      #1 check("rd_stall_req", bus.stall_o, 1);
      expect_ack(1'b0, 1'b0, 16'h6301, c + 3);
      @(negedge clk);   // RD1
      check("rd1_ce_n",  bus.sram_ce_n_o,  0);
      check("rd1_oe_n",  bus.sram_oe_n_o,  0);
      check("rd1_we_n",  bus.sram_we_n_o,  1);
      check("rd1_dq_oe", bus.sram_dq_oe_o, 0);
      check("rd1_addr",  bus.sram_addr_o,  16'h0040);
      @(negedge clk);   // RD2
      check("rd2_stall", bus.stall_o, 1);
      @(negedge clk);   // DONE
      check("rd_ack_stall", bus.stall_o, 0);
      bus.if_req_i = 1'b0;
      @(negedge clk);
      check_idle_pins("post_rd");

      // conflict: data first, then strict alternation while both stay asserted
      c = cyc;
      bus.if_req_i = 1'b1; bus.if_addr_i  = 16'h0100;
      bus.mem_rd_i = 1'b1; bus.mem_addr_i = 16'h0200;
      expect_ack(1'b1, 1'b0, 16'h2222, c + 3);
      expect_ack(1'b0, 1'b0, 16'h1111, c + 7);
      expect_ack(1'b1, 1'b0, 16'h2222, c + 11);
      expect_ack(1'b0, 1'b0, 16'h1111, c + 15);
      expect_ack(1'b1, 1'b0, 16'h2222, c + 19);
      nif = 0; nmem = 0;
      for (int i = 0; i < 40 && (bus.if_req_i || bus.mem_rd_i); i++) begin
         @(negedge clk);
         if (bus.if_ack_o) begin
            nif++;
            if (nif == 2) bus.if_req_i = 1'b0;
         end
         if (bus.mem_ack_o) begin
            nmem++;
            if (nmem == 3) bus.mem_rd_i = 1'b0;
         end
      end
      check("alt_acks", {nif[7:0], nmem[7:0]}, 16'h0203);
      @(negedge clk);

      // request dropped mid-access still completes
      c = cyc;
      bus.mem_rd_i = 1'b1; bus.mem_addr_i = 16'h0100;
      expect_ack(1'b1, 1'b0, 16'h1111, c + 3);
      @(negedge clk);
      bus.mem_rd_i = 1'b0;
      wait_ack_drop(1'b1);

      // rd+wr together -> write only, mem_rdata untouched
      c = cyc;
      bus.mem_rd_i = 1'b1; bus.mem_wr_i = 1'b1;
      bus.mem_addr_i = 16'h0010; bus.mem_wdata_i = 16'h0BEE;
      expect_ack(1'b1, 1'b1, 16'h0, c + 4);
      @(negedge clk);
      check("rdwr_dq_oe", bus.sram_dq_oe_o, 1);
      wait_ack_drop(1'b1);
      c = cyc;
      bus.mem_rd_i = 1'b1;
      expect_ack(1'b1, 1'b0, 16'h0BEE, c + 3);
      wait_ack_drop(1'b1);

      // reset during WR2: pins release immediately, no ack, then regrant
      bus.mem_wr_i = 1'b1; bus.mem_addr_i = 16'h0300; bus.mem_wdata_i = 16'h5A5A;
      @(negedge clk);
      @(negedge clk);
      check("rstw_wr2_we_n", bus.sram_we_n_o, 0);
      #1 rst = 1'b1;
      #1;
      check_idle_pins("rstw");
      check("rstw_addr",      bus.sram_addr_o, 0);
      check("rstw_dout",      bus.sram_dout_o, 0);
      check("rstw_mem_ack",   bus.mem_ack_o,   0);
      check("rstw_if_rdata",  bus.if_rdata_o,  0);
      check("rstw_mem_rdata", bus.mem_rdata_o, 0);
      mdl_if_rd  = 16'h0;
      mdl_mem_rd = 16'h0;
      repeat (2) @(negedge clk);
      c = cyc;
      rst = 1'b0;
      expect_ack(1'b1, 1'b1, 16'h0, c + 4);
      wait_ack_drop(1'b1);
      c = cyc;
      bus.mem_rd_i = 1'b1;
      expect_ack(1'b1, 1'b0, 16'h5A5A, c + 3);
      wait_ack_drop(1'b1);

      repeat (3) @(negedge clk);
      check("queue_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 rst  input  1  asynchronous, active-high reset.
REQ-003 if_req  input  1  instruction-fetch read request; held high until if_ack.
REQ-004 if_addr  input  16  fetch address.
REQ-005 if_rdata  output  16  fetched word, registered.
REQ-006 if_ack  output  1  one-cycle pulse: fetch complete, if_rdata valid in the same cycle.
REQ-007 mem_rd  input  1  data-stage read request; held until mem_ack.
REQ-008 mem_wr  input  1  data-stage write request; held until mem_ack.
REQ-009 mem_addr  input  16  data address.
REQ-010 mem_wdata  input  16  write data.
REQ-011 mem_rdata  output  16  data read result, registered.
REQ-012 mem_ack  output  1  one-cycle pulse: data access complete.
REQ-013 stall  output  1  pipeline freeze request to PC/IF/ID latches.
REQ-014 sram_addr  output  16  SRAM address bus.
REQ-015 sram_dout  output  16  SRAM write data; sram_dq_oe  output  1  drive enable for the bidirectional data bus.
REQ-016 sram_din  input  16  SRAM read data.
REQ-017 sram_ce_n, sram_oe_n, sram_we_n  output  1 each  active-low SRAM strobes.

Function
REQ-018 The FSM SHALL use the states IDLE, RD1, RD2, WR1, WR2, WR3, DONE, with all SRAM outputs registered from state.
REQ-019 In IDLE with no request, the block SHALL hold ce_n=oe_n=we_n=1 and dq_oe=0.
REQ-020 In IDLE, the block SHALL grant the data port first: mem_wr -> WR1, else mem_rd -> RD1, else if_req -> RD1 (fetch).
- Exception: if the previous grant was data and if_req is pending, fetch wins (one-deep alternation, no starvation).
REQ-021 mem_rd and mem_wr asserted together SHALL be treated as a write.
REQ-022 The granted address and write data SHALL be latched at the grant edge; later input changes SHALL be ignored until DONE.
REQ-023 Read: RD1 and RD2 SHALL drive ce_n=0, oe_n=0, we_n=1, dq_oe=0.
- At the RD2->DONE edge, sram_din SHALL be captured into if_rdata or mem_rdata per owner.
REQ-024 Write: WR1 drives ce_n=0, dq_oe=1, we_n=1; WR2 drives we_n=0; WR3 drives we_n=1 with address and data held; then DONE.
REQ-025 DONE SHALL pulse exactly one ack (owner's port) for one cycle, then return to IDLE.
- A request is never re-accepted in its own DONE cycle.
REQ-026 Latency from grant edge to ack: read 3 cycles, write 4 cycles.
- Back-to-back throughput: read 4 cycles, write 5 cycles.
REQ-027 The non-owner's rdata register SHALL hold its prior value across a transaction.
REQ-028 stall SHALL be combinational: (if_req & ~if_ack) | ((mem_rd|mem_wr) & ~mem_ack).
REQ-029 A request dropped before its ack (protocol violation) SHALL NOT abort an in-flight access; the access completes and ack still pulses.

Reset
REQ-030 rst SHALL, asynchronously and mid-transaction included, force: state=IDLE, ce_n=oe_n=we_n=1, dq_oe=0, acks=0, if_rdata=mem_rdata=0, sram_addr=sram_dout=0, last-grant=fetch.
REQ-031 The first grant after rst deasserts SHALL occur at the first rising edge with a request present.

Verification
REQ-032 Fetch read: if_req=1, if_addr=0x0040, sram_din=0x6301 -> if_ack pulses 3 cycles after grant, if_rdata=0x6301, stall high until the ack cycle.
REQ-033 Write: mem_wr=1, addr=0xBF00, wdata=0x00A5 -> we_n low exactly one cycle (WR2), sram_dout=0x00A5 and addr stable over WR1-WR3, mem_ack 4 cycles after grant.
REQ-034 Conflict: if_req and mem_rd both rise in IDLE -> data served first, then fetch. With mem_rd held for repeated requests, grants alternate data/fetch.
REQ-035 Reset mid-write: rst asserted during WR2 -> we_n=1, dq_oe=0 immediately (no clock edge), no ack; after release, a pending request is regranted.
REQ-036 Simultaneous mem_rd and mem_wr at 0x0010 -> write cycle performed, mem_rdata unchanged, single mem_ack.
